// File: rtl/dmem_obi_slave.sv
// OBI data-memory slave front-end: randomized grant/response wait states, single-cycle memory
// strobes, in-order responses through an outstanding FIFO, and a sticky protocol checker.
module dmem_obi_slave #(
  parameter int unsigned DW         = 33,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [3:0]    GNT_WMAX,
  input  logic [3:0]    RESP_WMAX,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [3:0]    data_be,
  input  logic          data_is_cap,
  input  logic [31:0]   data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic [7:0]    data_flag,
  output logic          data_gnt,
  output logic          data_rvalid,
  output logic [DW-1:0] data_rdata,
  output logic          data_err,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [7:0]    mem_flag,
  output logic [29:0]   mem_addr32,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_err,
  output logic          proto_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

  logic [15:0]   r_lfsr;
  logic          w_lfsr_fb;
  logic [4:0]    w_gdiv;
  logic [4:0]    w_rdiv;
  logic [3:0]    w_rnd_g;
  logic [3:0]    w_rnd_r;

  logic [3:0]    r_gcnt;
  logic [3:0]    r_rcnt;
  logic [CW-1:0] r_outs;
  logic          w_gnt;
  logic          w_hs;

  logic          r_p_vld;
  logic          r_p_we;
  logic          r_p_err;
  logic          w_push;
  logic [DW-1:0] w_push_data;
  logic          w_pop;
  logic          w_head_new;

  logic [DW-1:0]         r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_err;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_fcnt;

  logic          r_stall;
  logic          r_prev_we;
  logic [3:0]    r_prev_be;
  logic          r_prev_cap;
  logic [31:0]   r_prev_addr;
  logic [DW-1:0] r_prev_wdata;
  logic [7:0]    r_prev_flag;
  logic          r_proto;
  logic          w_viol;

  // Wait-state source: Fibonacci LFSR, taps 16,14,13,11
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_gdiv  = {1'b0, GNT_WMAX} + 5'd1;
  assign w_rdiv  = {1'b0, RESP_WMAX} + 5'd1;
  assign w_rnd_g = 4'({1'b0, r_lfsr[3:0]} % w_gdiv);
  assign w_rnd_r = 4'({1'b0, r_lfsr[7:4]} % w_rdiv);

  // Slot is reserved at grant, so the FIFO can never overflow
  assign w_gnt = rst_ni & data_req & (r_gcnt == 4'd0) & (r_outs < DepthC);
  assign w_hs  = w_gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_gcnt <= 4'd0;
    end else if (w_hs) begin
      r_gcnt <= w_rnd_g;
    end else if (data_req && (r_gcnt != 4'd0)) begin
      r_gcnt <= r_gcnt - 4'd1;
    end
  end

  assign mem_cs     = w_hs;
  assign mem_we     = data_we;
  assign mem_be     = data_be;
  assign mem_flag   = data_flag;
  assign mem_addr32 = data_addr[31:2];
  assign mem_wdata  = data_wdata;

  // mem_err belongs to the strobe cycle, mem_rdata to the following one
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_p_vld <= 1'b0;
      r_p_we  <= 1'b0;
      r_p_err <= 1'b0;
    end else begin
      r_p_vld <= w_hs;
      r_p_we  <= data_we;
      r_p_err <= mem_err;
    end
  end

  assign w_push      = r_p_vld;
  assign w_push_data = (r_p_we || r_p_err) ? '0 : mem_rdata;

  assign w_pop       = rst_ni & (r_fcnt != '0) & (r_rcnt == 4'd0);
  assign data_rvalid = w_pop;
  assign data_rdata  = w_pop ? r_fifo_data[r_rptr] : '0;
  assign data_err    = w_pop & r_fifo_err[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_push_data;
      r_fifo_err[r_wptr]  <= r_p_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      r_outs <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      case ({w_hs, w_pop})
        2'b10:   r_outs <= r_outs + CW'(1);
        2'b01:   r_outs <= r_outs - CW'(1);
        default: r_outs <= r_outs;
      endcase
    end
  end

  // A fresh entry reaches the head on a push into an empty FIFO or a pop that leaves one behind
  assign w_head_new = (w_push & (r_fcnt == '0)) |
                      (w_pop & ((r_fcnt != CW'(1)) | w_push));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rcnt <= 4'd0;
    end else if (w_head_new) begin
      r_rcnt <= w_rnd_r;
    end else if (r_rcnt != 4'd0) begin
      r_rcnt <= r_rcnt - 4'd1;
    end
  end

  // A stalled request (req & !gnt) must hold every attribute until granted
  assign w_viol = r_stall & (~data_req |
                             (data_we != r_prev_we) |
                             (data_be != r_prev_be) |
                             (data_is_cap != r_prev_cap) |
                             (data_addr != r_prev_addr) |
                             (data_wdata != r_prev_wdata) |
                             (data_flag != r_prev_flag));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall      <= 1'b0;
      r_prev_we    <= 1'b0;
      r_prev_be    <= 4'd0;
      r_prev_cap   <= 1'b0;
      r_prev_addr  <= 32'd0;
      r_prev_wdata <= '0;
      r_prev_flag  <= 8'd0;
      r_proto      <= 1'b0;
    end else begin
      r_stall      <= data_req & ~w_gnt;
      r_prev_we    <= data_we;
      r_prev_be    <= data_be;
      r_prev_cap   <= data_is_cap;
      r_prev_addr  <= data_addr;
      r_prev_wdata <= data_wdata;
      r_prev_flag  <= data_flag;
      r_proto      <= r_proto | w_viol;
    end
  end

  assign data_gnt  = w_gnt;
  assign proto_err = r_proto;

endmodule

// File: tb/tb_dmem_obi_slave.sv
// Directed bench for dmem_obi_slave: reset, read/write latency, backpressure, errors,
// protocol flag and reset with responses in flight.
module tb_dmem_obi_slave;

  localparam int unsigned DW = 33;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [3:0]    gnt_wmax;
  logic [3:0]    resp_wmax;
  logic          data_req;
  logic          data_we;
  logic [3:0]    data_be;
  logic          data_is_cap;
  logic [31:0]   data_addr;
  logic [DW-1:0] data_wdata;
  logic [7:0]    data_flag;
  logic          data_gnt;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          data_err;
  logic          mem_cs;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [7:0]    mem_flag;
  logic [29:0]   mem_addr32;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic          proto_err;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_obi_slave dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .GNT_WMAX    (gnt_wmax),
    .RESP_WMAX   (resp_wmax),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_is_cap (data_is_cap),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_flag   (data_flag),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .data_err    (data_err),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_flag    (mem_flag),
    .mem_addr32  (mem_addr32),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .proto_err   (proto_err)
  );

  function automatic logic [DW-1:0] mem_model(input logic [29:0] a);
    return {a[0], a ^ 30'h15A5_A5A5, 2'b10};
  endfunction

  // Memory: read data one cycle after the strobe, error in the strobe cycle
  logic          mrd_en;
  logic [DW-1:0] mrd_val;
  logic          err_en;
  logic [29:0]   err_addr;
  logic [29:0]   maddr_q;
  always @(posedge clk) maddr_q <= mem_addr32;
  assign mem_rdata = mrd_en ? mrd_val : mem_model(maddr_q);
  assign mem_err   = mem_cs & err_en & (mem_addr32 == err_addr);

  logic [DW:0] rv_q[$];
  int          rv_cyc[$];
  int          tb_outs   = 0;
  int          max_outs  = 0;
  int          outs_viol = 0;

  always @(negedge clk) begin
    int pre;
    if (!rst_ni) begin
      tb_outs = 0;
    end else begin
      pre = tb_outs;
      if (data_req && data_gnt && pre >= 4) outs_viol++;
      if (data_rvalid) begin
        rv_q.push_back({data_err, data_rdata});
        rv_cyc.push_back(cyc);
      end
      tb_outs = pre + ((data_req && data_gnt) ? 1 : 0) - (data_rvalid ? 1 : 0);
      if (tb_outs > max_outs) max_outs = tb_outs;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_rv();
    rv_q.delete();
    rv_cyc.delete();
  endtask

  task automatic wait_n(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rv_q.size() >= n) break;
      next_cyc();
    end
  endtask

  function automatic logic [DW:0] rv_at(input int j);
    if (j < rv_q.size()) return rv_q[j];
    return 'x;
  endfunction

  function automatic int rv_cyc_at(input int j);
    if (j < rv_cyc.size()) return rv_cyc[j];
    return -1000;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          tg;
    int          k;
    int          outs_pre;
    bit          found;
    logic [DW:0] exp_q[$];

    rst_ni      = 1'b0;
    gnt_wmax    = 4'd0;
    resp_wmax   = 4'd0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    data_be     = 4'hF;
    data_is_cap = 1'b0;
    data_addr   = 32'd0;
    data_wdata  = '0;
    data_flag   = 8'd0;
    mrd_en      = 1'b0;
    mrd_val     = '0;
    err_en      = 1'b0;
    err_addr    = 30'd0;

    // Reset state
    repeat (3) next_cyc();
    @(negedge clk);
    chk_eq("rst_gnt", data_gnt, 0);
    chk_eq("rst_rvalid", data_rvalid, 0);
    chk_eq("rst_rdata", data_rdata, 0);
    chk_eq("rst_err", data_err, 0);
    chk_eq("rst_cs", mem_cs, 0);
    chk_eq("rst_proto", proto_err, 0);
    next_cyc();
    rst_ni = 1'b1;
    next_cyc();
    clr_rv();

    // Single read, zero wait states
    mrd_en    = 1'b1;
    mrd_val   = 33'h1_1234_5678;
    data_req  = 1'b1;
    data_addr = 32'h8000_0010;
    @(negedge clk);
    tg = cyc;
    chk_eq("rd_gnt", data_gnt, 1);
    chk_eq("rd_cs", mem_cs, 1);
    chk_eq("rd_addr32", mem_addr32, 30'h2000_0004);
    next_cyc();
    data_req = 1'b0;
    wait_n(1, 10);
    repeat (3) next_cyc();
    chk_eq("rd_count", rv_q.size(), 1);
    chk_eq("rd_resp", rv_at(0), {1'b0, 33'h1_1234_5678});
    chk_eq("rd_lat", rv_cyc_at(0) - tg, 2);

    // Single write: response data must be zero even with live memory data
    clr_rv();
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_be    = 4'b0011;
    data_addr  = 32'h8000_0000;
    data_wdata = 33'h0_0000_BEEF;
    @(negedge clk);
    tg = cyc;
    chk_eq("wr_cs", mem_cs, 1);
    chk_eq("wr_we", mem_we, 1);
    chk_eq("wr_be", mem_be, 4'b0011);
    chk_eq("wr_wdata", mem_wdata, 33'h0_0000_BEEF);
    next_cyc();
    data_req = 1'b0;
    data_we  = 1'b0;
    data_be  = 4'hF;
    wait_n(1, 10);
    chk_eq("wr_resp", rv_at(0), 34'd0);
    chk_eq("wr_lat", rv_cyc_at(0) - tg, 2);
    mrd_en = 1'b0;

    // Eight back-to-back reads with long response waits
    clr_rv();
    resp_wmax = 4'd15;
    max_outs  = 0;
    outs_viol = 0;
    k         = 0;
    data_req  = 1'b1;
    data_addr = 32'h8000_0100;
    for (int i = 0; i < 300 && k < 8; i++) begin
      @(negedge clk);
      if (data_gnt) begin
        exp_q.push_back({1'b0, mem_model(data_addr[31:2])});
        k++;
      end
      next_cyc();
      if (k < 8) data_addr = 32'h8000_0100 + 32'(4 * k);
      else data_req = 1'b0;
    end
    data_req = 1'b0;
    chk_eq("burst_grants", k, 8);
    wait_n(8, 400);
    repeat (5) next_cyc();
    chk_eq("burst_count", rv_q.size(), 8);
    for (int j = 0; j < 8; j++) begin
      chk_eq($sformatf("burst_resp%0d", j), rv_at(j), exp_q[j]);
    end
    chk_eq("burst_gnt_when_full", outs_viol, 0);
    chk_eq("burst_max_outs_le4", max_outs <= 4, 1);
    chk_eq("burst_proto", proto_err, 0);

    // Error on the second of three reads
    clr_rv();
    resp_wmax = 4'd2;
    err_en    = 1'b1;
    err_addr  = 30'h2000_0081;
    k         = 0;
    data_req  = 1'b1;
    data_addr = 32'h8000_0200;
    for (int i = 0; i < 100 && k < 3; i++) begin
      @(negedge clk);
      if (data_gnt) k++;
      next_cyc();
      if (k < 3) data_addr = 32'h8000_0200 + 32'(4 * k);
      else data_req = 1'b0;
    end
    data_req = 1'b0;
    wait_n(3, 100);
    chk_eq("err_r0", rv_at(0), {1'b0, mem_model(30'h2000_0080)});
    chk_eq("err_r1", rv_at(1), {1'b1, 33'd0});
    chk_eq("err_r2", rv_at(2), {1'b0, mem_model(30'h2000_0082)});
    err_en = 1'b0;

    // Address change while stalled
    gnt_wmax  = 4'd7;
    resp_wmax = 4'd0;
    found     = 1'b0;
    data_req  = 1'b1;
    data_addr = 32'h8000_0300;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!data_gnt) begin
        found = 1'b1;
        break;
      end
      next_cyc();
    end
    chk_eq("proto_stall_seen", found, 1);
    chk_eq("proto_before", proto_err, 0);
    next_cyc();
    data_addr = 32'h8000_0304;
    @(negedge clk);
    chk_eq("proto_same_cycle", proto_err, 0);
    next_cyc();
    data_req = 1'b0;
    @(negedge clk);
    chk_eq("proto_set", proto_err, 1);
    repeat (5) next_cyc();
    chk_eq("proto_sticky", proto_err, 1);
    rst_ni = 1'b0;
    next_cyc();
    rst_ni = 1'b1;
    @(negedge clk);
    chk_eq("proto_cleared", proto_err, 0);
    next_cyc();

    // Reset with responses in flight
    gnt_wmax  = 4'd0;
    resp_wmax = 4'd15;
    k         = 0;
    data_req  = 1'b1;
    data_addr = 32'h8000_0400;
    for (int i = 0; i < 50 && k < 3; i++) begin
      @(negedge clk);
      if (data_gnt) k++;
      if (k == 3) break;
      next_cyc();
      data_addr = 32'h8000_0400 + 32'(4 * k);
    end
    next_cyc();
    data_req = 1'b0;
    outs_pre = tb_outs;
    rst_ni   = 1'b0;
    next_cyc();
    rst_ni = 1'b1;
    clr_rv();
    chk_eq("rst_inflight_pending", outs_pre >= 1, 1);
    repeat (30) next_cyc();
    chk_eq("rst_no_stale_rvalid", rv_q.size(), 0);

    resp_wmax = 4'd0;
    data_req  = 1'b1;
    data_addr = 32'h8000_0500;
    @(negedge clk);
    tg = cyc;
    chk_eq("post_rst_gnt", data_gnt, 1);
    next_cyc();
    data_req = 1'b0;
    wait_n(1, 10);
    chk_eq("post_rst_resp", rv_at(0), {1'b0, mem_model(30'h2000_0140)});
    chk_eq("post_rst_lat", rv_cyc_at(0) - tg, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
